// File: rtl/scale_ctrl.sv
// ============================================================================
// Module   : scale_ctrl
// Brief    : Frame-synchronous display scale selector with a 2-stage
//            camera frame-buffer address generator (240x320, row-major).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scale_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        btn_pulse_in,
    input  logic        new_frame_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    output logic [1:0]  scale_out,
    output logic        pending_out,
    output logic [16:0] addr_out,
    output logic        addr_valid_out
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t      state_q;
    logic [1:0]  scale_q;
    logic [1:0]  pend_q;
    logic        pending_q;

    function automatic logic [1:0] next_scale(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    // Commits only on a frame pulse, so the visible scale never changes mid-frame.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= ST_RUN;
            scale_q   <= 2'd0;
            pend_q    <= 2'd0;
            pending_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (btn_pulse_in) begin
                        pend_q    <= next_scale(scale_q);
                        state_q   <= ST_PEND;
                        pending_q <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (new_frame_in) begin
                        scale_q <= pend_q;
                    end
                    if (btn_pulse_in) begin
                        pend_q <= next_scale(pend_q);
                    end else if (new_frame_in) begin
                        state_q   <= ST_RUN;
                        pending_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_RUN;
                    pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign scale_out   = scale_q;
    assign pending_out = pending_q;

    logic [3:0]  k_d;
    logic [10:0] hlim_d;
    logic [9:0]  vlim_d;
    logic [13:0] hprod_d;
    logic [12:0] vprod_d;
    logic        inwin_d;
    logic [7:0]  col_d;
    logic [8:0]  row_d;

    always_comb begin
        k_d    = 4'd8;
        hlim_d = 11'd240;
        vlim_d = 10'd320;
        case (scale_q)
            2'd1: begin
                k_d    = 4'd4;
                hlim_d = 11'd480;
                vlim_d = 10'd640;
            end
            2'd2: begin
                k_d    = 4'd3;
                hlim_d = 11'd640;
                vlim_d = 10'd853;
            end
            default: ;
        endcase
    end

    // Window limits guarantee the truncated source coordinates fit 8/9 bits.
    assign hprod_d = {3'b000, hcount_in} * {10'd0, k_d};
    assign vprod_d = {3'b000, vcount_in} * {9'd0, k_d};
    assign inwin_d = (hcount_in < hlim_d) && (vcount_in < vlim_d);
    assign col_d   = inwin_d ? 8'(hprod_d >> 3) : 8'd0;
    assign row_d   = inwin_d ? 9'(vprod_d >> 3) : 9'd0;

    logic [7:0]  col_q;
    logic [8:0]  row_q;
    logic        inwin_q;
    logic [16:0] addr_d;
    logic [16:0] addr_q;
    logic        valid_q;

    assign addr_d = inwin_q ? ({row_q, 8'd0} - {4'd0, row_q, 4'd0} + {9'd0, col_q})
                            : 17'd0;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            col_q   <= 8'd0;
            row_q   <= 9'd0;
            inwin_q <= 1'b0;
            addr_q  <= 17'd0;
            valid_q <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            inwin_q <= inwin_d;
            addr_q  <= addr_d;
            valid_q <= inwin_q;
        end
    end

    assign addr_out       = addr_q;
    assign addr_valid_out = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_scale_ctrl.sv
// ============================================================================
// Module   : tb_scale_ctrl
// Brief    : Self-checking bench for scale_ctrl against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scale_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        btn_pulse_in;
    logic        new_frame_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [1:0]  scale_out;
    logic        pending_out;
    logic [16:0] addr_out;
    logic        addr_valid_out;

    scale_ctrl dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .btn_pulse_in   (btn_pulse_in),
        .new_frame_in   (new_frame_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .scale_out      (scale_out),
        .pending_out    (pending_out),
        .addr_out       (addr_out),
        .addr_valid_out (addr_valid_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic        v;
        logic [16:0] a;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   m_scale;
    int   m_pend;
    bit   m_pending;
    exp_t q[$];

    function automatic exp_t ref_map(int s, int h, int v);
        int   hl, vl, k;
        exp_t e;
        case (s)
            1:       begin hl = 480; vl = 640; k = 4; end
            2:       begin hl = 640; vl = 853; k = 3; end
            default: begin hl = 240; vl = 320; k = 8; end
        endcase
        e = '0;
        if (h < hl && v < vl) begin
            e.v = 1'b1;
            e.a = 17'(((v * k) / 8) * 240 + (h * k) / 8);
        end
        return e;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk_in);
        e = ref_map(m_scale, int'(hcount_in), int'(vcount_in));
        q.push_back(e);
        if (!m_pending) begin
            if (btn_pulse_in) begin
                m_pend    = (m_scale + 1) % 3;
                m_pending = 1'b1;
            end
        end else begin
            if (new_frame_in) m_scale = m_pend;
            if (btn_pulse_in) m_pend = (m_pend + 1) % 3;
            else if (new_frame_in) m_pending = 1'b0;
        end
        #1;
        check("scale", 32'(scale_out), 32'(m_scale));
        check("pending", 32'(pending_out), 32'(m_pending));
        check("addr", 32'(addr_out), 32'(q[0].a));
        check("valid", 32'(addr_valid_out), 32'(q[0].v));
        void'(q.pop_front());
    endtask

    task automatic model_reset();
        m_scale   = 0;
        m_pend    = 0;
        m_pending = 1'b0;
        q.delete();
        q.push_back('0);
    endtask

    // Asserts reset between edges and checks outputs clear without a clock.
    task automatic do_reset();
        #1 rst_in = 1'b1;
        #1;
        model_reset();
        check("rst_scale", 32'(scale_out), 32'd0);
        check("rst_pending", 32'(pending_out), 32'd0);
        check("rst_addr", 32'(addr_out), 32'd0);
        check("rst_valid", 32'(addr_valid_out), 32'd0);
        #1 rst_in = 1'b0;
    endtask

    task automatic press();
        btn_pulse_in = 1'b1;
        tick();
        btn_pulse_in = 1'b0;
    endtask

    task automatic frame();
        new_frame_in = 1'b1;
        tick();
        new_frame_in = 1'b0;
    endtask

    initial begin
        rst_in       = 1'b1;
        btn_pulse_in = 1'b0;
        new_frame_in = 1'b0;
        hcount_in    = 11'd0;
        vcount_in    = 10'd0;
        model_reset();
        #12;
        check("init_scale", 32'(scale_out), 32'd0);
        check("init_pending", 32'(pending_out), 32'd0);
        check("init_valid", 32'(addr_valid_out), 32'd0);
        rst_in    = 1'b0;
        hcount_in = 11'd700;
        tick();

        // Single press, frame five cycles later
        press();
        check("press_pending", 32'(pending_out), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_pending", 32'(pending_out), 32'd1);
            check("hold_scale", 32'(scale_out), 32'd0);
        end
        frame();
        check("commit_scale", 32'(scale_out), 32'd1);
        check("commit_pending", 32'(pending_out), 32'd0);

        // A lone frame pulse in RUN changes nothing
        frame();
        check("run_frame", 32'(scale_out), 32'd1);

        // Reach scale 2, then three presses wrap back to 2
        press();
        frame();
        check("to_two", 32'(scale_out), 32'd2);
        press(); tick(); press(); press();
        frame();
        check("wrap_scale", 32'(scale_out), 32'd2);

        // Simultaneous pulses while pending value is 1
        press(); press();
        btn_pulse_in = 1'b1;
        new_frame_in = 1'b1;
        tick();
        btn_pulse_in = 1'b0;
        new_frame_in = 1'b0;
        check("both_scale", 32'(scale_out), 32'd1);
        check("both_pending", 32'(pending_out), 32'd1);
        frame();
        check("both_pend_val", 32'(scale_out), 32'd2);

        // Scale 2 address corners
        hcount_in = 11'd639; vcount_in = 10'd852;
        tick();
        hcount_in = 11'd640; vcount_in = 10'd0;
        tick();
        check("max_addr", 32'(addr_out), 32'd76799);
        check("max_valid", 32'(addr_valid_out), 32'd1);
        tick();
        check("edge_addr", 32'(addr_out), 32'd0);
        check("edge_valid", 32'(addr_valid_out), 32'd0);

        // Scale 1 mapping
        press(); press();
        frame();
        hcount_in = 11'd3; vcount_in = 10'd5;
        tick();
        tick();
        check("s1_addr", 32'(addr_out), 32'd481);
        check("s1_valid", 32'(addr_valid_out), 32'd1);

        // Reset mid-PEND with valid output
        press();
        tick();
        do_reset();
        hcount_in = 11'd100; vcount_in = 10'd100;
        frame();
        check("post_rst_scale", 32'(scale_out), 32'd0);
        check("first_valid_lat1", 32'(addr_valid_out), 32'd0);
        tick();
        check("first_valid_lat2", 32'(addr_valid_out), 32'd1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            btn_pulse_in = ($urandom_range(0, 7) == 0);
            new_frame_in = ($urandom_range(0, 15) == 0);
            hcount_in    = 11'($urandom_range(0, 700));
            vcount_in    = 10'($urandom_range(0, 900));
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end
            tick();
        end
        btn_pulse_in = 1'b0;
        new_frame_in = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
